// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and register-index type for the scoreboarded register file
package regfile_pkg;
  localparam int RF_WIDTH    = 64;
  localparam int RF_DEPTH    = 32;
  localparam int RF_NRD      = 2;
  localparam int RF_ZERO_REG = RF_DEPTH - 1;
  localparam int RF_AW       = $clog2(RF_DEPTH);
  typedef logic [RF_AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port with zero-register masking, write-through bypass and busy lookup
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy,
  input  logic                        wr_valid,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [AW-1:0]               rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_busy
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
  localparam logic [AW:0]   DW = (AW+1)'(DEPTH);
  logic ok, byp;
  always_comb begin
    ok      = (rd_addr != ZR) && ({1'b0, rd_addr} < DW);
    byp     = ok && wr_valid && (wr_addr == rd_addr);
    rd_data = !ok ? '0 : byp ? wr_data : regs[rd_addr];
    rd_busy = ok && !byp && busy[rd_addr];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending-producer scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = DEPTH - 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][WIDTH-1:0] rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic                      rsv_ack,
  input  logic                      flush,
  output logic [AW:0]               busy_cnt
);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
  localparam logic [AW:0]   DW = (AW+1)'(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy, busy_nxt;
  logic [AW:0]                 cnt_nxt;
  logic                        wr_valid, rsv_ok, rsv_busy;
  // Gating with reset keeps bypass and ack quiet while the array is held clear
  always_comb begin
    wr_valid = reset && wr_en && (wr_addr != ZR) && ({1'b0, wr_addr} < DW);
    rsv_ok   = (rsv_addr != ZR) && ({1'b0, rsv_addr} < DW);
    rsv_busy = rsv_ok && busy[rsv_addr] && !(wr_valid && (wr_addr == rsv_addr));
    rsv_ack  = reset && rsv_en && rsv_ok && !rsv_busy && !flush;
  end
  always_comb begin
    busy_nxt = busy;
    if (wr_valid) busy_nxt[wr_addr] = 1'b0;
    if (rsv_ack) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_valid) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rd (
      .regs(regs), .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr[p]), .rd_data(rd_data[p]), .rd_busy(rd_busy[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenario bench for regfile_sb
module tb_regfile_sb;
  logic             clk, reset, wr_en, rsv_en, rsv_ack, flush;
  logic [4:0]       wr_addr, rsv_addr;
  logic [63:0]      wr_data;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][63:0] rd_data;
  logic [1:0]       rd_busy;
  logic [5:0]       busy_cnt;
  int checks, errors;

  regfile_sb dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ack(rsv_ack), .flush(flush), .busy_cnt(busy_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; flush = 0;
  endtask

  task automatic test_reset();
    rsv_en = 1; rsv_addr = 5'd3; wr_en = 1; wr_addr = 5'd2; wr_data = 64'hFF; rd_addr[0] = 5'd2; rd_addr[1] = 5'd3;
    #1;
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL reset_rd0 got %h exp 0", rd_data[0]); end
    checks++; if (rsv_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", rsv_ack); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    step();
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
    idle();
    @(negedge clk); reset = 1;
    step();
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL reset_wr_ignored got %h exp 0", rd_data[0]); end
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_rsv_ignored got %b exp 0", rd_busy[1]); end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF; rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
    step();
    wr_en = 0; #1;
    checks++; if (rd_data[0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd5 got %h exp deadbeef", rd_data[0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wr_rd5_busy got %b exp 0", rd_busy[0]); end
    checks++; if (rd_data[1] !== 64'h0) begin errors++; $display("FAIL rd6 got %h exp 0", rd_data[1]); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 5'd31; wr_data = 64'h1234;
    step();
    wr_en = 0; rd_addr[0] = 5'd31; rd_addr[1] = 5'd31; rsv_en = 1; rsv_addr = 5'd31; #1;
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL zero_rd0 got %h exp 0", rd_data[0]); end
    checks++; if (rd_data[1] !== 64'h0) begin errors++; $display("FAIL zero_rd1 got %h exp 0", rd_data[1]); end
    checks++; if (rsv_ack !== 1'b0) begin errors++; $display("FAIL zero_ack got %b exp 0", rsv_ack); end
    step();
    rsv_en = 0;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt got %0d exp 0", busy_cnt); end
    wr_en = 1; wr_addr = 5'd31; wr_data = 64'h77; #1;
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL zero_nobypass got %h exp 0", rd_data[0]); end
    wr_en = 0;
  endtask

  task automatic test_bypass();
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; #1;
    checks++; if (rd_data[1] !== 64'h0) begin errors++; $display("FAIL byp_pre got %h exp 0", rd_data[1]); end
    wr_en = 1; wr_addr = 5'd7; wr_data = 64'hA5; #1;
    checks++; if (rd_data[1] !== 64'hA5) begin errors++; $display("FAIL byp_rd1 got %h exp a5", rd_data[1]); end
    checks++; if (rd_data[0] !== 64'hA5) begin errors++; $display("FAIL byp_rd0 got %h exp a5", rd_data[0]); end
    step();
    wr_en = 0; rd_addr[0] = 5'd5; #1;
    checks++; if (rd_data[1] !== 64'hA5) begin errors++; $display("FAIL byp_stored got %h exp a5", rd_data[1]); end
    checks++; if (rd_data[0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL indep_rd0 got %h exp deadbeef", rd_data[0]); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 5'd3; rd_addr[0] = 5'd3; #1;
    checks++; if (rsv_ack !== 1'b1) begin errors++; $display("FAIL rsv3_ack got %b exp 1", rsv_ack); end
    step();
    checks++; if (rsv_ack !== 1'b0) begin errors++; $display("FAIL rsv3_reack got %b exp 0", rsv_ack); end
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsv3_busy got %b exp 1", rd_busy[0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv3_cnt got %0d exp 1", busy_cnt); end
    step();
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv3_cnt_hold got %0d exp 1", busy_cnt); end
    rsv_en = 0; wr_en = 1; wr_addr = 5'd3; wr_data = 64'h33; #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wr3_byp_busy got %b exp 0", rd_busy[0]); end
    checks++; if (rd_data[0] !== 64'h33) begin errors++; $display("FAIL wr3_byp_data got %h exp 33", rd_data[0]); end
    step();
    wr_en = 0; #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL wr3_cnt got %0d exp 0", busy_cnt); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wr3_busy got %b exp 0", rd_busy[0]); end
  endtask

  task automatic test_wr_rsv_same();
    rsv_en = 1; rsv_addr = 5'd10; rd_addr[1] = 5'd10;
    step();
    wr_en = 1; wr_addr = 5'd10; wr_data = 64'h10; #1;
    checks++; if (rsv_ack !== 1'b1) begin errors++; $display("FAIL same_ack got %b exp 1", rsv_ack); end
    step();
    idle(); #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL same_cnt got %0d exp 1", busy_cnt); end
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", rd_busy[1]); end
    checks++; if (rd_data[1] !== 64'h10) begin errors++; $display("FAIL same_data got %h exp 10", rd_data[1]); end
    wr_en = 1; wr_addr = 5'd10; wr_data = 64'h11;
    step();
    wr_en = 0;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL same_clear got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_flush();
    rsv_en = 1; rsv_addr = 5'd1; step();
    rsv_addr = 5'd2; step();
    rsv_addr = 5'd4; step();
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", busy_cnt); end
    rsv_addr = 5'd6; flush = 1; wr_en = 1; wr_addr = 5'd12; wr_data = 64'hC; #1;
    checks++; if (rsv_ack !== 1'b0) begin errors++; $display("FAIL flush_ack got %b exp 0", rsv_ack); end
    step();
    idle(); rd_addr[0] = 5'd6; rd_addr[1] = 5'd12; #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", busy_cnt); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL flush_busy6 got %b exp 0", rd_busy[0]); end
    checks++; if (rd_data[1] !== 64'hC) begin errors++; $display("FAIL flush_wr12 got %h exp c", rd_data[1]); end
    rd_addr[0] = 5'd4; #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL flush_busy4 got %b exp 0", rd_busy[0]); end
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 5'd9; wr_data = 64'h99; step();
    wr_en = 0; rsv_en = 1; rsv_addr = 5'd9; step();
    rsv_en = 0; rd_addr[0] = 5'd9; rd_addr[1] = 5'd5; #1;
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got %b exp 1", rd_busy[0]); end
    #2; reset = 0; wr_en = 1; wr_addr = 5'd9; wr_data = 64'h55; #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", rd_busy[0]); end
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL ar_rd0 got %h exp 0", rd_data[0]); end
    checks++; if (rd_data[1] !== 64'h0) begin errors++; $display("FAIL ar_rd1 got %h exp 0", rd_data[1]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", busy_cnt); end
    step();
    idle();
    @(negedge clk); reset = 1; #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL ar_post_busy got %b exp 0", rd_busy[0]); end
    checks++; if (rd_data[0] !== 64'h0) begin errors++; $display("FAIL ar_post_data got %h exp 0", rd_data[0]); end
    rsv_en = 1; rsv_addr = 5'd9; #1;
    checks++; if (rsv_ack !== 1'b1) begin errors++; $display("FAIL ar_post_ack got %b exp 1", rsv_ack); end
    step();
    rsv_en = 0;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL ar_post_cnt got %0d exp 1", busy_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 0; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0; rsv_en = 0; rsv_addr = '0; flush = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_wr_rsv_same();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
